// File: rtl/thread_scheduler.sv
// Round-robin barrel scheduler: per-thread DISABLED/READY/BLOCKED tracking plus
// a rotating-priority pick of the next issuing thread each unstalled cycle.

module thread_state (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_block,
    input  logic i_wake,
    output logic o_ready,
    output logic o_blocked,
    output logic o_err
);
    typedef enum logic [1:0] {ST_DIS, ST_RDY, ST_BLK} state_t;

    state_t r_state;

    // A block on a BLOCKED thread is legal only when its wake lands the same
    // cycle: the old access retires as the new one starts.
    assign o_err = (i_wake && (r_state != ST_BLK)) ||
                   (i_block && (r_state != ST_RDY) && !((r_state == ST_BLK) && i_wake));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_DIS;
            o_ready   <= 1'b0;
            o_blocked <= 1'b0;
        end else if (!i_enable) begin
            r_state   <= ST_DIS;
            o_ready   <= 1'b0;
            o_blocked <= 1'b0;
        end else begin
            case (r_state)
                ST_DIS: begin
                    r_state <= ST_RDY;
                    o_ready <= 1'b1;
                end
                ST_RDY: begin
                    if (i_block) begin
                        r_state   <= ST_BLK;
                        o_ready   <= 1'b0;
                        o_blocked <= 1'b1;
                    end
                end
                ST_BLK: begin
                    if (i_wake && !i_block) begin
                        r_state   <= ST_RDY;
                        o_ready   <= 1'b1;
                        o_blocked <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_DIS;
                    o_ready   <= 1'b0;
                    o_blocked <= 1'b0;
                end
            endcase
        end
    end
endmodule

module thread_scheduler #(
    parameter int THREAD_INDEX_BITS = 3,
    parameter int NUM_THREADS       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_THREADS-1:0]       in_thread_enable,
    input  logic                         in_stall,
    input  logic                         in_block_valid,
    input  logic [THREAD_INDEX_BITS-1:0] in_block_thread,
    input  logic                         in_wake_valid,
    input  logic [THREAD_INDEX_BITS-1:0] in_wake_thread,
    output logic                         out_issue_valid,
    output logic [THREAD_INDEX_BITS-1:0] out_thread_index,
    output logic [NUM_THREADS-1:0]       out_ready_mask,
    output logic [NUM_THREADS-1:0]       out_blocked_mask,
    output logic                         out_protocol_error
);
    logic [NUM_THREADS-1:0]       w_blk_vec;
    logic [NUM_THREADS-1:0]       w_wake_vec;
    logic [NUM_THREADS-1:0]       w_err_vec;
    logic [NUM_THREADS-1:0]       w_ready;
    logic [NUM_THREADS-1:0]       w_blocked;
    logic [NUM_THREADS-1:0]       w_cand;
    logic                         w_found;
    logic                         w_err;
    logic [THREAD_INDEX_BITS-1:0] w_winner;
    logic [THREAD_INDEX_BITS-1:0] w_next_ptr;
    logic [THREAD_INDEX_BITS-1:0] r_rr_ptr;
    logic                         r_err;

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
        assign w_blk_vec[g]  = in_block_valid && (in_block_thread == THREAD_INDEX_BITS'(g));
        assign w_wake_vec[g] = in_wake_valid  && (in_wake_thread  == THREAD_INDEX_BITS'(g));

        thread_state u_thr (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_enable  (in_thread_enable[g]),
            .i_block   (w_blk_vec[g]),
            .i_wake    (w_wake_vec[g]),
            .o_ready   (w_ready[g]),
            .o_blocked (w_blocked[g]),
            .o_err     (w_err_vec[g])
        );
    end

    // An index that decodes to no thread is out of range.
    assign w_err = (|w_err_vec) ||
                   (in_block_valid && !(|w_blk_vec)) ||
                   (in_wake_valid  && !(|w_wake_vec));

    // A thread being blocked this cycle already has its access in flight.
    assign w_cand = w_ready & ~w_blk_vec;

    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        // Walk farthest-first so the nearest candidate from r_rr_ptr wins.
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= NUM_THREADS) v_idx = v_idx - NUM_THREADS;
            if (w_cand[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx[THREAD_INDEX_BITS-1:0];
            end
        end
    end

    assign w_next_ptr = (w_winner == THREAD_INDEX_BITS'(NUM_THREADS - 1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_issue_valid  <= 1'b0;
            out_thread_index <= '0;
            r_rr_ptr         <= '0;
            r_err            <= 1'b0;
        end else begin
            r_err <= r_err | w_err;
            if (!in_stall) begin
                if (w_found) begin
                    out_issue_valid  <= 1'b1;
                    out_thread_index <= w_winner;
                    r_rr_ptr         <= w_next_ptr;
                end else begin
                    out_issue_valid  <= 1'b0;
                end
            end
        end
    end

    assign out_ready_mask     = w_ready;
    assign out_blocked_mask   = w_blocked;
    assign out_protocol_error = r_err;
endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: hand-computed issue sequences, masks,
// stall hold, block/wake, protocol errors and asynchronous reset.

module tb_thread_scheduler;
    logic       clk;
    logic       rst_n;
    logic [7:0] in_thread_enable;
    logic       in_stall;
    logic       in_block_valid;
    logic [2:0] in_block_thread;
    logic       in_wake_valid;
    logic [2:0] in_wake_thread;
    logic       out_issue_valid;
    logic [2:0] out_thread_index;
    logic [7:0] out_ready_mask;
    logic [7:0] out_blocked_mask;
    logic       out_protocol_error;

    int n_pass  = 0;
    int n_total = 0;

    thread_scheduler #(.THREAD_INDEX_BITS(3), .NUM_THREADS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_thread_enable  (in_thread_enable),
        .in_stall          (in_stall),
        .in_block_valid    (in_block_valid),
        .in_block_thread   (in_block_thread),
        .in_wake_valid     (in_wake_valid),
        .in_wake_thread    (in_wake_thread),
        .out_issue_valid   (out_issue_valid),
        .out_thread_index  (out_thread_index),
        .out_ready_mask    (out_ready_mask),
        .out_blocked_mask  (out_blocked_mask),
        .out_protocol_error(out_protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_issue(input string tag, input logic v, input logic [2:0] idx);
        chk({tag, ".valid"}, 32'(out_issue_valid), 32'(v));
        chk({tag, ".index"}, 32'(out_thread_index), 32'(idx));
    endtask

    initial begin
        int e;
        rst_n = 1'b0; in_thread_enable = 8'h00; in_stall = 1'b0;
        in_block_valid = 1'b0; in_block_thread = 3'd0;
        in_wake_valid = 1'b0; in_wake_thread = 3'd0;

        // Reset values
        #12;
        chk_issue("reset", 1'b0, 3'd0);
        chk("reset.ready", 32'(out_ready_mask), 32'h00);
        chk("reset.blocked", 32'(out_blocked_mask), 32'h00);
        chk("reset.err", 32'(out_protocol_error), 32'd0);
        rst_n = 1'b1;

        // Enable all: READY after edge 1, first issue (thread 0) after edge 2
        in_thread_enable = 8'hFF;
        tick();
        chk("en1.ready", 32'(out_ready_mask), 32'hFF);
        chk_issue("en1", 1'b0, 3'd0);
        tick();
        chk_issue("en2", 1'b1, 3'd0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk_issue("rr_all", 1'b1, 3'(i % 8));
        end

        // Sparse enable; pointer sits at 2 so thread 2 still wins this edge
        in_thread_enable = 8'b1010_0100;
        tick();
        chk_issue("sparse0", 1'b1, 3'd2);
        chk("sparse.ready", 32'(out_ready_mask), 32'hA4);
        tick(); chk_issue("sparse1", 1'b1, 3'd5);
        tick(); chk_issue("sparse2", 1'b1, 3'd7);
        tick(); chk_issue("sparse3", 1'b1, 3'd2);
        tick(); chk_issue("sparse4", 1'b1, 3'd5);
        tick(); chk_issue("sparse5", 1'b1, 3'd7);

        // Disable all: one more issue from still-READY state, then none
        in_thread_enable = 8'h00;
        tick();
        chk_issue("dis1", 1'b1, 3'd2);
        chk("dis1.ready", 32'(out_ready_mask), 32'h00);
        chk("dis1.blocked", 32'(out_blocked_mask), 32'h00);
        tick();
        chk_issue("dis2", 1'b0, 3'd2);

        // Re-enable; pointer is 3, block(3) on the edge it would win
        in_thread_enable = 8'hFF;
        tick();
        chk_issue("reen", 1'b0, 3'd2);
        in_block_valid = 1'b1; in_block_thread = 3'd3;
        tick();
        in_block_valid = 1'b0;
        chk_issue("blk3", 1'b1, 3'd4);
        chk("blk3.blocked", 32'(out_blocked_mask), 32'h08);
        chk("blk3.ready", 32'(out_ready_mask), 32'hF7);
        chk("blk3.err", 32'(out_protocol_error), 32'd0);
        e = 4;
        for (int i = 0; i < 9; i++) begin
            e = (e + 1) % 8;
            if (e == 3) e = 4;
            tick();
            chk_issue("skip3", 1'b1, 3'(e));
        end
        // After the loop e == 6; wake(3) on the 10th edge after the block
        in_wake_valid = 1'b1; in_wake_thread = 3'd3;
        tick();
        in_wake_valid = 1'b0;
        chk_issue("wake3", 1'b1, 3'd7);
        chk("wake3.blocked", 32'(out_blocked_mask), 32'h00);
        chk("wake3.ready", 32'(out_ready_mask), 32'hFF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_issue("after_wake", 1'b1, 3'(i));
        end

        // Stall right after thread 6 issues
        tick(); chk_issue("pre_stall4", 1'b1, 3'd4);
        tick(); chk_issue("pre_stall5", 1'b1, 3'd5);
        tick(); chk_issue("pre_stall6", 1'b1, 3'd6);
        in_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_issue("stall", 1'b1, 3'd6);
        end
        in_stall = 1'b0;
        tick();
        chk_issue("unstall", 1'b1, 3'd7);

        // Block 2, then block+wake 2 together: stays BLOCKED, no error
        in_block_valid = 1'b1; in_block_thread = 3'd2;
        tick();
        chk_issue("blk2", 1'b1, 3'd0);
        chk("blk2.blocked", 32'(out_blocked_mask), 32'h04);
        in_wake_valid = 1'b1; in_wake_thread = 3'd2;
        tick();
        in_block_valid = 1'b0; in_wake_valid = 1'b0;
        chk_issue("blkwake2", 1'b1, 3'd1);
        chk("blkwake2.blocked", 32'(out_blocked_mask), 32'h04);
        chk("blkwake2.err", 32'(out_protocol_error), 32'd0);
        tick();
        chk_issue("skip2", 1'b1, 3'd3);

        // Wake of a READY thread is a protocol error and is ignored
        in_wake_valid = 1'b1; in_wake_thread = 3'd5;
        tick();
        in_wake_valid = 1'b0;
        chk("wake5.err", 32'(out_protocol_error), 32'd1);
        chk("wake5.ready", 32'(out_ready_mask), 32'hFB);
        chk_issue("wake5", 1'b1, 3'd4);
        tick();
        chk("err_sticky", 32'(out_protocol_error), 32'd1);
        chk_issue("post_err", 1'b1, 3'd5);

        // Block 4, then disable it while BLOCKED, then re-enable -> READY
        in_block_valid = 1'b1; in_block_thread = 3'd4;
        tick();
        in_block_valid = 1'b0;
        chk_issue("blk4", 1'b1, 3'd6);
        chk("blk4.blocked", 32'(out_blocked_mask), 32'h14);
        in_thread_enable = 8'hEF;
        tick();
        chk_issue("dis4", 1'b1, 3'd7);
        chk("dis4.blocked", 32'(out_blocked_mask), 32'h04);
        chk("dis4.ready", 32'(out_ready_mask), 32'hEB);
        in_thread_enable = 8'hFF;
        tick();
        chk_issue("reen4", 1'b1, 3'd0);
        chk("reen4.ready", 32'(out_ready_mask), 32'hFB);
        chk("reen4.blocked", 32'(out_blocked_mask), 32'h04);

        // Asynchronous reset mid-run, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk_issue("areset", 1'b0, 3'd0);
        chk("areset.ready", 32'(out_ready_mask), 32'h00);
        chk("areset.blocked", 32'(out_blocked_mask), 32'h00);
        chk("areset.err", 32'(out_protocol_error), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst.ready", 32'(out_ready_mask), 32'hFF);
        chk_issue("post_rst1", 1'b0, 3'd0);
        tick();
        chk_issue("post_rst2", 1'b1, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Round-robin barrel scheduler for the multithreaded integer pipeline. Each cycle it picks which hardware thread issues next into the fetch/decode front end. It tracks a per-thread DISABLED/READY/BLOCKED state, so threads with an outstanding load/store are parked until memory completion wakes them. Sits between the thread-enable configuration register and the fetch stage; its `out_thread_index` is the value later carried down the datapath as `in_thread_index`.

## Interface
- `THREAD_INDEX_BITS`, 3: width of a thread index.
- `NUM_THREADS`, 8: number of hardware threads; must be ≤ 2^THREAD_INDEX_BITS and ≥ 2.
- `clk` input 1: rising-edge clock; the only clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_thread_enable` input NUM_THREADS: per-thread enable; bit t=0 forces thread t DISABLED.
- `in_stall` input 1: front end cannot accept; scheduler holds outputs and pointer.
- `in_block_valid` input 1: a load/store was issued by `in_block_thread`.
- `in_block_thread` input THREAD_INDEX_BITS: thread to block.
- `in_wake_valid` input 1: memory completion for `in_wake_thread`.
- `in_wake_thread` input THREAD_INDEX_BITS: thread to wake.
- `out_issue_valid` output 1: `out_thread_index` is a valid issue slot.
- `out_thread_index` output THREAD_INDEX_BITS: thread issuing this cycle.
- `out_ready_mask` output NUM_THREADS: registered, bit t=1 iff thread t is READY.
- `out_blocked_mask` output NUM_THREADS: registered, bit t=1 iff thread t is BLOCKED.
- `out_protocol_error` output 1: sticky error flag.

## Operation
- **Per-thread FSM.** States are DISABLED, READY and BLOCKED; all threads are DISABLED at reset. Priority per edge, highest first:
  - `in_thread_enable[t]`=0 → DISABLED, discarding any pending block or wake.
  - DISABLED with enable=1 → READY.
  - READY with block(t) → BLOCKED.
  - BLOCKED with wake(t) and no block(t) → READY.
  - BLOCKED with wake(t) and block(t) in the same cycle → stays BLOCKED: the old access completes and a new one starts.
  - Otherwise the thread holds its state.
- **Protocol errors.** `out_protocol_error` sets on any of:
  - wake(t) while t is not BLOCKED;
  - block(t) while t is not READY;
  - block or wake thread index ≥ NUM_THREADS.
  
  The offending event is ignored and the flag clears only on reset.
- **Selection.**
  - Candidate mask = threads READY in the current state, with any thread named by a valid block this cycle removed.
  - Search starts at `rr_ptr` and increments mod NUM_THREADS; the first candidate wins.
- **Issue update.** On each edge with `in_stall`=0:
  - With a candidate: `out_issue_valid`←1, `out_thread_index`←winner, `rr_ptr`←(winner+1) mod NUM_THREADS.
  - With no candidate: `out_issue_valid`←0 and `out_thread_index` and `rr_ptr` hold.
- **Stall.** On an edge with `in_stall`=1, `out_issue_valid`, `out_thread_index` and `rr_ptr` hold. Thread FSMs, masks and the error flag still update.
- **Fairness.** Each READY thread issues at least once every NUM_THREADS unstalled cycles.

## Timing
- **Reset values** (asynchronous on `rst_n`=0):
  - `out_issue_valid`=0, `out_thread_index`=0.
  - `out_ready_mask`=0, `out_blocked_mask`=0.
  - `out_protocol_error`=0, `rr_ptr`=0.
- **Reset mid-operation.** All threads are DISABLED immediately and `out_issue_valid` drops asynchronously. Pending blocks and wakes are lost.
- **Deassertion.** All inputs are registered from the first rising edge after `rst_n` deasserts.
- **Enable latency.** Enable rising before edge k makes the thread READY after edge k. The thread can win at edge k+1, so it appears on the outputs after edge k+1: 2 cycles.
- **Block latency.** A block sampled at edge k takes effect in the same cycle: the thread cannot win at edge k. It is BLOCKED after edge k.
- **Wake latency.** A wake sampled at edge k makes the thread READY after edge k. The thread can win at edge k+1.
- **Mask timing.** `out_ready_mask` and `out_blocked_mask` reflect state after the edge; no combinational paths from inputs to outputs.
- **Throughput.** One issue per unstalled cycle whenever at least one candidate exists.

## Test plan
- **Reset then enable.** Reset, then enable=8'hFF with no stall → issues 0,1,2,...,7,0,... on consecutive cycles. The first valid issue, thread 0, appears 2 edges after enable.
- **Sparse enable.** enable=8'b1010_0100 → issue sequence 2,5,7,2,5,7. Enable=0 → `out_issue_valid`=0 after 2 edges and both masks are 0.
- **Block and wake.** With all threads READY and thread 3 about to win, assert block(3):
  - 3 is skipped the same cycle; 4 issues instead.
  - `out_blocked_mask`=8'h08 and thread 3 never issues.
  - wake(3) 10 cycles later → thread 3 issues again within 8 cycles, and no earlier than the edge after the wake.
- **Stall hold.** Stall for 5 cycles mid-sequence right after thread 6 issues → `out_thread_index` holds 6 and valid holds. After release the next issue is 7.
- **Simultaneous events and errors.** Thread 2 BLOCKED, block(2) and wake(2) in the same cycle → stays BLOCKED with no error. Then wake(5) while thread 5 is READY → `out_protocol_error`=1, thread 5 stays READY, and the flag persists until `rst_n` pulses.
- **Disable and reset mid-operation.** Thread 4 BLOCKED, enable[4] dropped → thread 4 goes DISABLED. Re-enabling it → READY, not BLOCKED. Asserting `rst_n`=0 mid-run → all outputs return to their reset values without waiting for a clock edge.
